// File: rtl/gnrc_sched_pkg.sv
// Shared types and helpers for the weighted round-robin scheduler.
// Types are sized for the default configuration; modules size their own nets from parameters.
package gnrc_sched_pkg;
  localparam int SCHED_N  = 8;
  localparam int SCHED_WW = 4;

  typedef logic [$clog2(SCHED_N)-1:0] sel_t;
  typedef logic [SCHED_WW-1:0]        cred_t;

  // A zero weight still earns one burst per round so nobody starves.
  function automatic int norm_weight(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int rr_next(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/gnrc_rr_pick.sv
// Cyclic first-one finder: lowest set bit of vec_i at or after ptr_i, wrapping at N.
module gnrc_rr_pick
  import gnrc_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  int j;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (vec_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/gnrc_wrr_sched.sv
// Weighted round-robin scheduler with burst locking onto one downstream valid/ready port.
// Selection and outputs are combinational from inputs and state.
module gnrc_wrr_sched
  import gnrc_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    last_i,
  input  logic [N*WW-1:0] weight_i,
  input  logic [N*DW-1:0] data_i,
  output logic [N-1:0]    gnt_o,
  output logic            req_o,
  output logic [DW-1:0]   data_o,
  output logic [IW-1:0]   idx_o,
  input  logic            gnt_i
);
  logic [IW-1:0]        ptr_q, ptr_d, owner_q, owner_d;
  logic                 locked_q, locked_d;
  logic [N-1:0][WW-1:0] cred_q, cred_d, wnorm;
  logic [N-1:0]         cr_vec;
  logic [IW-1:0]        sel, cr_idx, rp_idx;
  logic                 cr_found, rp_found, replenish, hs, sel_last;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign wnorm[g]  = WW'(norm_weight(int'(weight_i[g*WW +: WW])));
    assign cr_vec[g] = req_i[g] & (cred_q[g] != '0);
  end

  gnrc_rr_pick #(.N(N), .IW(IW)) u_pick_cr (
    .vec_i(cr_vec), .ptr_i(ptr_q), .found_o(cr_found), .idx_o(cr_idx)
  );

  gnrc_rr_pick #(.N(N), .IW(IW)) u_pick_rp (
    .vec_i(req_i), .ptr_i(ptr_q), .found_o(rp_found), .idx_o(rp_idx)
  );

  // Replenish only when requesters exist and every one of them is out of credit.
  always_comb begin
    replenish = 1'b0;
    if (rst_i)         sel = ptr_q;
    else if (locked_q) sel = owner_q;
    else if (cr_found) sel = cr_idx;
    else if (rp_found) begin
      sel       = rp_idx;
      replenish = 1'b1;
    end
    else               sel = ptr_q;
  end

  always_comb begin
    sel_last   = last_i[sel];
    req_o      = req_i[sel] & ~rst_i;
    hs         = req_o & gnt_i;
    gnt_o      = '0;
    gnt_o[sel] = hs;
    idx_o      = sel;
    data_o     = data_i[int'(sel)*DW +: DW];
  end

  always_comb begin
    ptr_d    = ptr_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    cred_d   = cred_q;
    if (flush_i) begin
      ptr_d    = '0;
      locked_d = 1'b0;
      owner_d  = '0;
      cred_d   = '0;
    end
    else begin
      if (replenish) cred_d = wnorm;
      if (hs && !sel_last) begin
        locked_d = 1'b1;
        owner_d  = sel;
      end
      else if (hs) begin
        locked_d = 1'b0;
        if (cred_d[sel] != '0) cred_d[sel] = cred_d[sel] - 1'b1;
        // Keep the pointer on a requester that still has credit so it can win again.
        ptr_d = (cred_d[sel] == '0) ? IW'(rr_next(int'(sel), N)) : sel;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      locked_q <= 1'b0;
      owner_q  <= '0;
      cred_q   <= '0;
    end
    else begin
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      cred_q   <= cred_d;
    end
  end
endmodule

// File: tb/tb_gnrc_wrr_sched.sv
// Directed bench for gnrc_wrr_sched (N=4): literal per-test expectations plus a
// per-cycle reference model of the scheduling rules.
module tb_gnrc_wrr_sched;
  localparam int N = 4, DW = 8, WW = 4, IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, gnt_i;
  logic [N-1:0]    req_i, last_i, gnt_o;
  logic [N*WW-1:0] weight_i;
  logic [N*DW-1:0] data_i;
  logic            req_o;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   idx_o;

  int vectors = 0, miscompares = 0;
  bit chk_en = 0;

  gnrc_wrr_sched #(.N(N), .DW(DW), .WW(WW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i), .last_i(last_i),
    .weight_i(weight_i), .data_i(data_i), .gnt_o(gnt_o), .req_o(req_o),
    .data_o(data_o), .idx_o(idx_o), .gnt_i(gnt_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: abstract state and rule-level next-state computation.
  int m_ptr = 0, m_owner = 0;
  bit m_locked = 0;
  int m_cred[N] = '{default: 0};

  always @(negedge clk_i) begin
    int e_sel, j, w;
    bit found, repl, e_req, hs;
    logic [N-1:0] e_gnt;
    if (chk_en) begin
      found = 0; repl = 0; e_sel = m_ptr;
      if (!rst_i && m_locked) e_sel = m_owner;
      else if (!rst_i) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && req_i[j] && m_cred[j] > 0) begin e_sel = j; found = 1; end
        end
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && req_i[j]) begin e_sel = j; found = 1; repl = 1; end
        end
      end
      e_req = !rst_i && req_i[e_sel];
      hs    = e_req && gnt_i;
      e_gnt = '0;
      if (hs) e_gnt[e_sel] = 1'b1;
      chk("model_idx", 32'(idx_o), 32'(e_sel));
      chk("model_req", 32'(req_o), 32'(e_req));
      chk("model_gnt", 32'(gnt_o), 32'(e_gnt));
      chk("model_data", 32'(data_o), 32'(data_i[e_sel*DW +: DW]));
      if (rst_i || flush_i) begin
        m_ptr = 0; m_owner = 0; m_locked = 0;
        for (int i = 0; i < N; i++) m_cred[i] = 0;
      end
      else begin
        if (repl)
          for (int i = 0; i < N; i++) begin
            w = int'(weight_i[i*WW +: WW]);
            m_cred[i] = (w == 0) ? 1 : w;
          end
        if (hs && !last_i[e_sel]) begin
          m_locked = 1; m_owner = e_sel;
        end
        else if (hs) begin
          m_locked = 0;
          if (m_cred[e_sel] > 0) m_cred[e_sel]--;
          m_ptr = (m_cred[e_sel] == 0) ? (e_sel + 1) % N : e_sel;
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic do_rst();
    rst_i = 1; flush_i = 0; req_i = 4'hF; last_i = 4'hF; gnt_i = 1;
    @(negedge clk_i);
    chk("rst_req", 32'(req_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    next_cyc();
    rst_i = 0; req_i = 0; last_i = 0;
  endtask

  int t2[6] = '{0, 1, 2, 3, 0, 1};
  int t3[8] = '{0, 1, 1, 1, 0, 1, 1, 1};
  logic [3:0] onehot;

  initial begin
    rst_i = 1; flush_i = 0; req_i = 0; last_i = 0; gnt_i = 0;
    weight_i = 16'h1111; data_i = 32'h04030201;
    next_cyc();
    chk_en = 1;
    do_rst();

    // Test 1: idle after reset
    @(negedge clk_i);
    chk("t1_req", 32'(req_o), 0);
    chk("t1_gnt", 32'(gnt_o), 0);
    chk("t1_idx", 32'(idx_o), 0);
    chk("t1_data", 32'(data_o), 32'h01);
    next_cyc();

    // Test 2: unit weights, all requesting single beats
    req_i = 4'hF; last_i = 4'hF; gnt_i = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      onehot = 4'b0001 << t2[k];
      chk("t2_idx", 32'(idx_o), 32'(t2[k]));
      chk("t2_gnt", 32'(gnt_o), 32'(onehot));
      if (k < 4) chk("t2_data", 32'(data_o), 32'(k + 1));
      next_cyc();
    end

    // Test 3: requester 1 weighted 3
    weight_i = 16'h1131;
    do_rst();
    req_i = 4'h3; last_i = 4'h3; gnt_i = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      chk("t3_idx", 32'(idx_o), 32'(t3[k]));
      next_cyc();
    end

    // Test 4: four-beat burst from requester 0 locks out requester 2
    weight_i = 16'h1111;
    do_rst();
    req_i = 4'h5; gnt_i = 1;
    for (int k = 0; k < 4; k++) begin
      last_i = (k == 3) ? 4'h5 : 4'h4;
      @(negedge clk_i);
      chk("t4_idx_burst", 32'(idx_o), 0);
      chk("t4_gnt_burst", 32'(gnt_o), 32'h1);
      next_cyc();
    end
    @(negedge clk_i);
    chk("t4_idx_after", 32'(idx_o), 2);
    chk("t4_gnt_after", 32'(gnt_o), 32'h4);
    next_cyc();

    // Test 5: back-pressure while requester 2 owns the port
    do_rst();
    req_i = 4'h4; last_i = 4'h0; gnt_i = 1;
    @(negedge clk_i);
    chk("t5_first", 32'(idx_o), 2);
    next_cyc();
    gnt_i = 0;
    for (int k = 0; k < 5; k++) begin
      req_i = (k % 2 == 0) ? 4'h7 : 4'hF;
      @(negedge clk_i);
      chk("t5_stall_idx", 32'(idx_o), 2);
      chk("t5_stall_gnt", 32'(gnt_o), 0);
      chk("t5_stall_req", 32'(req_o), 1);
      next_cyc();
    end
    req_i = 4'hF; gnt_i = 1; last_i = 4'h4;
    @(negedge clk_i);
    chk("t5_release", 32'(gnt_o), 32'h4);
    next_cyc();
    last_i = 4'hF;
    @(negedge clk_i);
    chk("t5_next_idx", 32'(idx_o), 3);
    next_cyc();

    // Test 6: flush in the middle of requester 1's burst
    do_rst();
    req_i = 4'h2; last_i = 4'h0; gnt_i = 1;
    @(negedge clk_i);
    chk("t6_lock", 32'(idx_o), 1);
    next_cyc();
    req_i = 4'h3; flush_i = 1;
    @(negedge clk_i);
    chk("t6_flush_fwd", 32'(gnt_o), 32'h2);
    next_cyc();
    flush_i = 0; gnt_i = 0;
    @(negedge clk_i);
    chk("t6_idx", 32'(idx_o), 0);
    chk("t6_req", 32'(req_o), 1);
    next_cyc();
    gnt_i = 1; last_i = 4'h3;
    @(negedge clk_i);
    chk("t6_gnt0", 32'(gnt_o), 32'h1);
    next_cyc();
    @(negedge clk_i);
    chk("t6_idx1", 32'(idx_o), 1);
    next_cyc();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
